// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder/controller state encoding, bus mode and default frame settings.
package spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [1:0]  SPI_MODE          = 2'd0;
    localparam logic        SPI_CPOL          = SPI_MODE[1];
    localparam int unsigned SPI_DEF_WIDTH     = 32'd8;
    localparam logic [7:0]  SPI_DEF_IDLE_WORD = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with single-cycle rise/fall strobes
// derived from the synchronized level and one history flop.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain plus history flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~hist_q;
    assign o_fall  = ~o_level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples SCLK/CS_n/MOSI in the i_clk domain, shifts WIDTH-bit
// frames MSB-first, and sources TX words from a one-entry holding buffer.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned      WIDTH       = SPI_DEF_WIDTH,
    parameter int unsigned      SYNC_STAGES = 32'd2,
    parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(SPI_DEF_IDLE_WORD)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_underrun,
    output logic             o_busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 32'd1);

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_sync_s;

    spi_state_e       state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             last_rise_q;
    logic [WIDTH-2:0] rx_sr_q;
    logic [WIDTH-2:0] tx_sr_q;
    logic [WIDTH-1:0] buf_q;
    logic             tx_ready_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             underrun_q;
    logic             miso_q;
    logic             busy_q;

    logic             cs_evt_s;
    logic             wr_s;
    logic             load_s;
    logic [WIDTH-1:0] load_word_s;
    logic [WIDTH-1:0] rx_word_d;
    logic [WIDTH-1:0] tx_shift_d;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sclk),
        .o_level (sclk_level_s),
        .o_rise  (sclk_rise_s),
        .o_fall  (sclk_fall_s)
    );

    // CS resets to "asserted" so a frame already running when reset lifts never produces a cs_fall
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cs_n),
        .o_level (cs_level_s),
        .o_rise  (cs_rise_s),
        .o_fall  (cs_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_mosi),
        .o_level (mosi_s),
        .o_rise  (mosi_rise_s),
        .o_fall  (mosi_fall_s)
    );

    assign unused_sync_s = sclk_level_s ^ cs_level_s ^ mosi_rise_s ^ mosi_fall_s;

    // Frame-load decision, buffer write qualification and shift-register next values
    always_comb begin
        cs_evt_s    = cs_rise_s | cs_fall_s;
        wr_s        = i_tx_valid & tx_ready_q;
        load_word_s = tx_ready_q ? IDLE_WORD : buf_q;
        rx_word_d   = {rx_sr_q, mosi_s};
        tx_shift_d  = {tx_sr_q, 1'b0};
        load_s      = 1'b0;
        case (state_q)
            ST_IDLE:   load_s = cs_fall_s;
            ST_ACTIVE: load_s = ~cs_evt_s & sclk_fall_s & last_rise_q;
            default:   load_s = 1'b0;
        endcase
    end

    // Responder FSM, shift registers, TX holding buffer and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            last_rise_q <= 1'b0;
            rx_sr_q     <= {(WIDTH-1){1'b0}};
            tx_sr_q     <= {(WIDTH-1){1'b0}};
            buf_q       <= {WIDTH{1'b0}};
            tx_ready_q  <= 1'b1;
            rx_data_q   <= {WIDTH{1'b0}};
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= load_s & tx_ready_q;

            // A load on an empty buffer still lets a same-cycle write fill it for the next frame
            if (load_s && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end else if (wr_s) begin
                buf_q      <= i_tx_data;
                tx_ready_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_q     <= ST_ACTIVE;
                        busy_q      <= 1'b1;
                        bit_cnt_q   <= {CNT_W{1'b0}};
                        last_rise_q <= 1'b0;
                        miso_q      <= load_word_s[WIDTH-1];
                        tx_sr_q     <= load_word_s[WIDTH-2:0];
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise_s) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= {CNT_W{1'b0}};
                        last_rise_q <= 1'b0;
                        miso_q      <= 1'b0;
                    end else if (cs_fall_s) begin
                        last_rise_q <= last_rise_q;
                    end else if (sclk_rise_s) begin
                        rx_sr_q <= rx_word_d[WIDTH-2:0];
                        if (bit_cnt_q == LAST_CNT) begin
                            bit_cnt_q   <= {CNT_W{1'b0}};
                            rx_data_q   <= rx_word_d;
                            rx_valid_q  <= 1'b1;
                            last_rise_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall_s) begin
                        if (last_rise_q) begin
                            last_rise_q <= 1'b0;
                            miso_q      <= load_word_s[WIDTH-1];
                            tx_sr_q     <= load_word_s[WIDTH-2:0];
                        end else begin
                            miso_q  <= tx_shift_d[WIDTH-1];
                            tx_sr_q <= tx_shift_d[WIDTH-2:0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_miso     = miso_q;
    assign o_miso_oe  = busy_q;
    assign o_busy     = busy_q;
    assign o_tx_ready = tx_ready_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a bit-banged mode-0 controller drives frames, expected
// RX words and expected MISO words are queued at stimulus time and popped as results appear.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, underrun, busy;

    int n_cmp = 0;
    int n_err = 0;
    int rx_pulses = 0;
    int under_pulses = 0;
    bit busy_mon = 1'b0;
    int cs_low_cyc = 0;
    int busy_cyc = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];

    always #5 clk = ~clk;

    spi_peripheral #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sclk     (sclk),
        .i_cs_n     (cs_n),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_underrun (underrun),
        .o_busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on rx_valid, pulse counters
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_pulses++;
            check_eq("rx_expected_pending", exp_rx_q.size() > 0, 1);
            if (exp_rx_q.size() > 0) check_eq("rx_data", rx_data, exp_rx_q.pop_front());
        end
        if (underrun) under_pulses++;
        if (busy_mon && busy) busy_cyc++;
    end

    always @(posedge clk) begin
        if (busy_mon && !cs_n) cs_low_cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tx_write(input logic [7:0] d);
        check_eq("tx_ready_before_write", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    // Mode-0 controller: half = SCLK half period in clk cycles, abort_after = rises before CS release (0 = full)
    task automatic spi_frame(input int half, input int nwords, input logic [7:0] w0,
                             input logic [7:0] w1, input int abort_after);
        logic [7:0] words [2];
        logic [7:0] cap;
        int         rises;
        bit         done;
        words[0] = w0;
        words[1] = w1;
        rises = 0;
        done  = 1'b0;
        if (abort_after == 0) begin
            for (int w = 0; w < nwords; w++) exp_rx_q.push_back(words[w]);
        end
        cs_n = 1'b0;
        for (int w = 0; w < nwords && !done; w++) begin
            cap = 8'h00;
            for (int b = 7; b >= 0 && !done; b--) begin
                mosi = words[w][b];
                repeat (half) @(negedge clk);
                cap[b] = miso;
                if (w == 0 && b == 7) check_eq("miso_oe_selected", miso_oe, 1);
                sclk = 1'b1;
                repeat (half) @(negedge clk);
                rises++;
                if (abort_after != 0 && rises == abort_after) done = 1'b1;
                else if (!(w == nwords - 1 && b == 0)) sclk = 1'b0;
            end
            if (!done) begin
                check_eq("miso_expected_pending", exp_miso_q.size() > 0, 1);
                if (exp_miso_q.size() > 0) check_eq("miso_word", cap, exp_miso_q.pop_front());
            end
        end
        cs_n = 1'b1;
        repeat (half) @(negedge clk);
        sclk = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    initial begin
        int rx0, un0, t;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;

        // 1: reset with CS and SCLK toggling
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cs_n = ~cs_n;
            if (i % 3 == 0) sclk = ~sclk;
        end
        check_eq("rst_miso", miso, 0);
        check_eq("rst_miso_oe", miso_oe, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_busy", busy, 0);
        cs_n = 1'b1; sclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_tx_ready", tx_ready, 1);
        check_eq("post_rst_rx_pulses", rx_pulses, 0);
        check_eq("post_rst_underruns", under_pulses, 0);

        // 2: preload 3C, receive A5, divisor 8
        rx0 = rx_pulses; un0 = under_pulses;
        tx_write(8'h3C);
        check_eq("t2_ready_after_write", tx_ready, 0);
        exp_miso_q.push_back(8'h3C);
        fork
            spi_frame(4, 1, 8'hA5, 8'h00, 0);
            begin
                repeat (6) @(negedge clk);
                check_eq("t2_ready_at_frame_start", tx_ready, 1);
            end
        join
        repeat (4) @(negedge clk);
        check_eq("t2_rx_pulses", rx_pulses - rx0, 1);
        check_eq("t2_underruns", under_pulses - un0, 0);

        // 3: two words under one CS, second TX word written mid-frame
        rx0 = rx_pulses; un0 = under_pulses;
        tx_write(8'h12);
        exp_miso_q.push_back(8'h12);
        exp_miso_q.push_back(8'h34);
        fork
            spi_frame(4, 2, 8'hF0, 8'h0F, 0);
            begin
                t = 0;
                while (!tx_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("t3_ready_in_time", t < 200, 1);
                tx_write(8'h34);
            end
        join
        repeat (4) @(negedge clk);
        check_eq("t3_rx_pulses", rx_pulses - rx0, 2);
        check_eq("t3_underruns", under_pulses - un0, 0);

        // 4: empty buffer underrun
        rx0 = rx_pulses; un0 = under_pulses;
        exp_miso_q.push_back(8'hFF);
        spi_frame(4, 1, 8'h55, 8'h00, 0);
        repeat (4) @(negedge clk);
        check_eq("t4_underruns", under_pulses - un0, 1);
        check_eq("t4_rx_pulses", rx_pulses - rx0, 1);
        check_eq("t4_rx_data_held", rx_data, 8'h55);

        // 5: frame aborted after 3 rises, then a full frame
        rx0 = rx_pulses;
        spi_frame(4, 1, 8'hE7, 8'h00, 3);
        check_eq("t5_oe_after_abort", miso_oe, 0);
        check_eq("t5_busy_after_abort", busy, 0);
        check_eq("t5_abort_rx_pulses", rx_pulses - rx0, 0);
        tx_write(8'h5A);
        exp_miso_q.push_back(8'h5A);
        spi_frame(4, 1, 8'hC3, 8'h00, 0);
        repeat (4) @(negedge clk);
        check_eq("t5_rx_pulses", rx_pulses - rx0, 1);

        // 6: slow SCLK, busy window tracks CS
        rx0 = rx_pulses;
        tx_write(8'h81);
        exp_miso_q.push_back(8'h81);
        busy_mon = 1'b1;
        spi_frame(50, 1, 8'h81, 8'h00, 0);
        repeat (10) @(negedge clk);
        busy_mon = 1'b0;
        check_eq("t6_rx_pulses", rx_pulses - rx0, 1);
        check_eq("t6_cs_low_seen", cs_low_cyc > 0, 1);
        check_eq("t6_busy_window", busy_cyc, cs_low_cyc);

        repeat (20) @(negedge clk);
        check_eq("rx_queue_drained", exp_rx_q.size(), 0);
        check_eq("miso_queue_drained", exp_miso_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
